// File: rtl/audio_ctrl_pkg.sv
// Shared types and constants for the voice-recorder sequencer and its SRAM mux.
package audio_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRewind = 2'd1,
    StRecord = 2'd2,
    StPlay   = 2'd3
  } state_e;

  localparam int unsigned DefaultFramesPerSec = 32000;
  localparam logic [17:0] SramLastAddr        = 18'h3FFFF;

endpackage

// File: rtl/sram_bus_mux.sv
// Combinational mux of the Codec read/write buses onto the single external SRAM.
module sram_bus_mux #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 16
) (
  input  logic              mode_rec_i,
  input  logic              mode_play_i,
  input  logic              codec_write_i,
  input  logic [ADDR_W-1:0] codec_waddr_i,
  input  logic [DATA_W-1:0] codec_wdata_i,
  input  logic              codec_read_i,
  input  logic [ADDR_W-1:0] codec_raddr_i,
  output logic [DATA_W-1:0] codec_rdata_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_we_no,
  output logic              sram_oe_no,
  inout  wire  [DATA_W-1:0] sram_dq_io
);

  logic wr_en;
  logic rd_en;

  // Strobes that do not match the current mode never reach the pins.
  assign wr_en = mode_rec_i & codec_write_i;
  assign rd_en = mode_play_i & codec_read_i;

  assign sram_dq_io = wr_en ? codec_wdata_i : {DATA_W{1'bz}};

  always_comb begin
    sram_addr_o   = '0;
    sram_we_no    = 1'b1;
    sram_oe_no    = 1'b1;
    codec_rdata_o = '0;
    if (wr_en) begin
      sram_addr_o = codec_waddr_i;
      sram_we_no  = 1'b0;
    end else if (rd_en) begin
      sram_addr_o   = codec_raddr_i;
      sram_oe_no    = 1'b0;
      codec_rdata_o = sram_dq_io;
    end
  end

endmodule

// File: rtl/audio_ctrl.sv
// Record/play sequencer: key decode, Codec controls, recorded-length tracking,
// elapsed-seconds count and SRAM bus ownership.
module audio_ctrl
  import audio_ctrl_pkg::*;
#(
  parameter int unsigned FRAMES_PER_SEC = DefaultFramesPerSec,
  parameter int unsigned ADDR_W         = 18,
  parameter int unsigned DATA_W         = 16
) (
  input  logic              AUD_BCLK,
  input  logic              rst_n,
  input  logic              key_record,
  input  logic              key_play,
  input  logic              key_stop,
  input  logic              sw_fast,
  input  logic [2:0]        sw_rate,
  input  logic              AUD_ADCLRCK,
  input  logic              AUD_DACLRCK,
  output logic              codec_record,
  output logic              codec_stop,
  output logic              codec_fast,
  output logic [2:0]        codec_rate,
  input  logic              codec_read,
  input  logic [ADDR_W-1:0] codec_raddr,
  output logic [DATA_W-1:0] codec_rdata,
  input  logic              codec_write,
  input  logic [ADDR_W-1:0] codec_waddr,
  input  logic [DATA_W-1:0] codec_wdata,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_UB_N,
  output logic [1:0]        o_state,
  output logic [7:0]        o_seconds,
  output logic              o_rec_valid
);

  localparam logic [14:0] FrameLast = 15'(FRAMES_PER_SEC - 1);

  state_e            state_q, state_d;
  state_e            target_q, target_d;
  logic              rew_cnt_q, rew_cnt_d;
  logic [ADDR_W-1:0] rec_end_q, rec_end_d;
  logic              codec_stop_q, codec_stop_d;
  logic              codec_record_q, codec_record_d;
  logic              codec_fast_q, codec_fast_d;
  logic [2:0]        codec_rate_q, codec_rate_d;
  logic              adc_q, dac_q;
  logic [14:0]       frame_q, frame_d;
  logic [7:0]        secs_q, secs_d;

  logic   rec_valid;
  logic   go_rewind;
  state_e go_target;
  logic   tick;
  logic   entering;

  assign rec_valid = |rec_end_q;

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    rew_cnt_d = rew_cnt_q;
    rec_end_d = rec_end_q;
    go_rewind = 1'b0;
    go_target = target_q;
    case (state_q)
      StIdle: begin
        if (key_stop) begin
          state_d = StIdle;
        end else if (key_record) begin
          go_rewind = 1'b1;
          go_target = StRecord;
        end else if (key_play && rec_valid) begin
          go_rewind = 1'b1;
          go_target = StPlay;
        end
      end
      StRewind: begin
        // Two cycles of stop=1 let the Codec clear its address before the take.
        if (rew_cnt_q) state_d = target_q;
        else           rew_cnt_d = 1'b1;
      end
      StRecord: begin
        if (codec_write) rec_end_d = codec_waddr;
        if (key_stop) begin
          state_d = StIdle;
        end else if (key_record) begin
          go_rewind = 1'b1;
          go_target = StRecord;
        end else if (key_play) begin
          go_rewind = 1'b1;
          go_target = StPlay;
        end else if (codec_write && (codec_waddr == {ADDR_W{1'b1}})) begin
          state_d = StIdle;
        end
      end
      StPlay: begin
        if (key_stop) begin
          state_d = StIdle;
        end else if (key_record) begin
          go_rewind = 1'b1;
          go_target = StRecord;
        end else if (key_play) begin
          go_rewind = 1'b1;
          go_target = StPlay;
        end else if (codec_read && (codec_raddr >= rec_end_q)) begin
          // Fast play may step over rec_end, hence >= rather than ==.
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (go_rewind) begin
      state_d   = StRewind;
      target_d  = go_target;
      rew_cnt_d = 1'b0;
      if (go_target == StRecord) rec_end_d = '0;
    end
  end

  always_comb begin
    codec_stop_d   = (state_d == StIdle) || (state_d == StRewind);
    codec_record_d = (state_d == StRecord);
    codec_fast_d   = (state_d == StPlay) & sw_fast;
    codec_rate_d   = (state_d == StPlay) ? sw_rate : 3'd0;
  end

  assign tick = ((state_q == StRecord) && AUD_ADCLRCK && !adc_q) ||
                ((state_q == StPlay) && !AUD_DACLRCK && dac_q);
  assign entering = (state_d != state_q) && ((state_d == StRecord) || (state_d == StPlay));

  always_comb begin
    frame_d = frame_q;
    secs_d  = secs_q;
    if (entering) begin
      frame_d = '0;
      secs_d  = '0;
    end else if (tick) begin
      if (frame_q == FrameLast) begin
        frame_d = '0;
        if (secs_q != 8'hFF) secs_d = secs_q + 8'd1;
      end else begin
        frame_d = frame_q + 15'd1;
      end
    end
  end

  always_ff @(posedge AUD_BCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      target_q       <= StIdle;
      rew_cnt_q      <= 1'b0;
      rec_end_q      <= '0;
      codec_stop_q   <= 1'b1;
      codec_record_q <= 1'b0;
      codec_fast_q   <= 1'b0;
      codec_rate_q   <= 3'd0;
      adc_q          <= 1'b0;
      dac_q          <= 1'b0;
      frame_q        <= '0;
      secs_q         <= '0;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      rew_cnt_q      <= rew_cnt_d;
      rec_end_q      <= rec_end_d;
      codec_stop_q   <= codec_stop_d;
      codec_record_q <= codec_record_d;
      codec_fast_q   <= codec_fast_d;
      codec_rate_q   <= codec_rate_d;
      adc_q          <= AUD_ADCLRCK;
      dac_q          <= AUD_DACLRCK;
      frame_q        <= frame_d;
      secs_q         <= secs_d;
    end
  end

  assign codec_stop   = codec_stop_q;
  assign codec_record = codec_record_q;
  assign codec_fast   = codec_fast_q;
  assign codec_rate   = codec_rate_q;
  assign o_state      = state_q;
  assign o_seconds    = secs_q;
  assign o_rec_valid  = rec_valid;
  assign SRAM_CE_N    = 1'b0;
  assign SRAM_LB_N    = 1'b0;
  assign SRAM_UB_N    = 1'b0;

  sram_bus_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_sram_bus_mux (
    .mode_rec_i   (state_q == StRecord),
    .mode_play_i  (state_q == StPlay),
    .codec_write_i(codec_write),
    .codec_waddr_i(codec_waddr),
    .codec_wdata_i(codec_wdata),
    .codec_read_i (codec_read),
    .codec_raddr_i(codec_raddr),
    .codec_rdata_o(codec_rdata),
    .sram_addr_o  (SRAM_ADDR),
    .sram_we_no   (SRAM_WE_N),
    .sram_oe_no   (SRAM_OE_N),
    .sram_dq_io   (SRAM_DQ)
  );

endmodule

// File: tb/tb_audio_ctrl.sv
// Randomized and directed bench for audio_ctrl against a behavioural model.
module tb_audio_ctrl;

  localparam int unsigned Fps = 4;
  localparam int unsigned AW  = 18;
  localparam int unsigned DW  = 16;
  localparam int Idle   = 0;
  localparam int Rewind = 1;
  localparam int Record = 2;
  localparam int Play   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          key_record = 1'b0, key_play = 1'b0, key_stop = 1'b0;
  logic          sw_fast = 1'b0;
  logic [2:0]    sw_rate = 3'd0;
  logic          adclrck = 1'b0, daclrck = 1'b0;
  logic          codec_record, codec_stop, codec_fast;
  logic [2:0]    codec_rate;
  logic          codec_read = 1'b0, codec_write = 1'b0;
  logic [AW-1:0] codec_raddr = '0, codec_waddr = '0;
  logic [DW-1:0] codec_wdata = '0, codec_rdata;
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_dq;
  logic          sram_we_n, sram_oe_n, sram_ce_n, sram_lb_n, sram_ub_n;
  logic [1:0]    o_state;
  logic [7:0]    o_seconds;
  logic          o_rec_valid;
  logic [DW-1:0] tb_rdata = '0;

  // SRAM device model: drives the bus only while output-enabled.
  assign sram_dq = (!sram_oe_n) ? tb_rdata : {DW{1'bz}};

  always #5 clk = ~clk;

  audio_ctrl #(
    .FRAMES_PER_SEC(Fps),
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .AUD_BCLK(clk), .rst_n(rst_n),
    .key_record(key_record), .key_play(key_play), .key_stop(key_stop),
    .sw_fast(sw_fast), .sw_rate(sw_rate),
    .AUD_ADCLRCK(adclrck), .AUD_DACLRCK(daclrck),
    .codec_record(codec_record), .codec_stop(codec_stop),
    .codec_fast(codec_fast), .codec_rate(codec_rate),
    .codec_read(codec_read), .codec_raddr(codec_raddr), .codec_rdata(codec_rdata),
    .codec_write(codec_write), .codec_waddr(codec_waddr), .codec_wdata(codec_wdata),
    .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq),
    .SRAM_WE_N(sram_we_n), .SRAM_OE_N(sram_oe_n), .SRAM_CE_N(sram_ce_n),
    .SRAM_LB_N(sram_lb_n), .SRAM_UB_N(sram_ub_n),
    .o_state(o_state), .o_seconds(o_seconds), .o_rec_valid(o_rec_valid)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model
  int            m_state, m_target, m_left, m_frames, m_secs;
  logic [AW-1:0] m_rec_end;
  logic          m_fast, m_prev_adc, m_prev_dac;
  logic [2:0]    m_rate;

  function automatic void model_reset();
    m_state = Idle; m_target = Idle; m_left = 0; m_frames = 0; m_secs = 0;
    m_rec_end = '0; m_fast = 1'b0; m_rate = 3'd0; m_prev_adc = 1'b0; m_prev_dac = 1'b0;
  endfunction

  function automatic void start_rewind(input int tgt);
    m_state = Rewind; m_target = tgt; m_left = 2;
    if (tgt == Record) m_rec_end = '0;
  endfunction

  function automatic void model_step();
    int  key;  // 0 none, 1 stop, 2 record, 3 play
    int  prev;
    bit  tick;
    key  = key_stop ? 1 : key_record ? 2 : key_play ? 3 : 0;
    tick = (m_state == Record && adclrck && !m_prev_adc) ||
           (m_state == Play && !daclrck && m_prev_dac);
    m_prev_adc = adclrck;
    m_prev_dac = daclrck;
    if (tick) begin
      m_frames++;
      if (m_frames == Fps) begin
        m_frames = 0;
        if (m_secs < 255) m_secs++;
      end
    end
    prev = m_state;
    case (m_state)
      Idle: begin
        if (key == 2) start_rewind(Record);
        else if (key == 3 && m_rec_end != 0) start_rewind(Play);
      end
      Rewind: begin
        m_left--;
        if (m_left == 0) m_state = m_target;
      end
      default: begin
        if (m_state == Record && codec_write) m_rec_end = codec_waddr;
        if (key == 1) m_state = Idle;
        else if (key == 2) start_rewind(Record);
        else if (key == 3) start_rewind(Play);
        else if (m_state == Record && codec_write && codec_waddr == 18'h3FFFF) m_state = Idle;
        else if (m_state == Play && codec_read && codec_raddr >= m_rec_end) m_state = Idle;
      end
    endcase
    if (m_state != prev && (m_state == Record || m_state == Play)) begin
      m_frames = 0;
      m_secs   = 0;
    end
    m_fast = (m_state == Play) ? sw_fast : 1'b0;
    m_rate = (m_state == Play) ? sw_rate : 3'd0;
  endfunction

  task automatic check_comb();
    bit wr, rd;
    wr = (m_state == Record) && codec_write;
    rd = (m_state == Play) && codec_read;
    check("we_n", sram_we_n, !wr);
    check("oe_n", sram_oe_n, !rd);
    check("addr", sram_addr, wr ? codec_waddr : rd ? codec_raddr : '0);
    if (wr) check("dq", sram_dq, codec_wdata);
    check("rdata", codec_rdata, rd ? tb_rdata : '0);
    check("ties", {sram_ce_n, sram_lb_n, sram_ub_n}, 3'b000);
  endtask

  task automatic check_regs();
    check("state", o_state, m_state);
    check("stop", codec_stop, (m_state == Idle || m_state == Rewind));
    check("record", codec_record, m_state == Record);
    check("fast", codec_fast, m_fast);
    check("rate", codec_rate, m_rate);
    check("rec_valid", o_rec_valid, m_rec_end != 0);
    check("seconds", o_seconds, m_secs);
  endtask

  // Inputs are set by the caller shortly after a rising edge; pulses last one cycle.
  task automatic cycle();
    #1;
    check_comb();
    @(posedge clk);
    model_step();
    #1;
    check_regs();
    key_record = 1'b0; key_play = 1'b0; key_stop = 1'b0;
    codec_write = 1'b0; codec_read = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic lrck_edge();
    adclrck = 1'b1; cycle();
    adclrck = 1'b0; cycle();
  endtask

  logic [AW-1:0] wptr, rptr;

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #20;
    check("rst_state", o_state, Idle);
    check("rst_stop", codec_stop, 1'b1);
    check("rst_record", codec_record, 1'b0);
    check("rst_seconds", o_seconds, 8'd0);
    check("rst_valid", o_rec_valid, 1'b0);
    check("rst_we_n", sram_we_n, 1'b1);
    check("rst_oe_n", sram_oe_n, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Play with nothing recorded is ignored.
    key_play = 1'b1; cycle();
    check("play_norec_state", o_state, Idle);
    check("play_norec_oe", sram_oe_n, 1'b1);

    // Record entry via a two-cycle rewind.
    key_record = 1'b1; cycle();
    check("rew1_state", o_state, Rewind);
    cycle();
    check("rew2_stop", codec_stop, 1'b1);
    cycle();
    check("rec_state", o_state, Record);
    check("rec_ctl", {codec_record, codec_stop}, 2'b10);

    codec_write = 1'b1; codec_waddr = 18'h00010; codec_wdata = 16'hBEEF;
    #1;
    check("wr_we_n", sram_we_n, 1'b0);
    check("wr_dq", sram_dq, 16'hBEEF);
    cycle();
    check("wr_valid", o_rec_valid, 1'b1);

    // SRAM full ends the take.
    codec_write = 1'b1; codec_waddr = 18'h3FFFF; cycle();
    check("full_state", o_state, Idle);
    check("full_valid", o_rec_valid, 1'b1);

    // Record up to 0x100, then play it back.
    key_record = 1'b1; cycle(); idle_cycles(2);
    for (int a = 0; a <= 'h100; a++) begin
      codec_write = 1'b1; codec_waddr = AW'(a); codec_wdata = DW'($urandom); cycle();
    end
    key_stop = 1'b1; cycle();
    sw_fast = 1'b1; sw_rate = 3'd4;
    key_play = 1'b1; cycle(); idle_cycles(2);
    check("play_state", o_state, Play);
    check("play_fast", {codec_fast, codec_rate}, 4'b1100);
    codec_read = 1'b1; codec_raddr = 18'h000FF; tb_rdata = 16'h1234;
    #1;
    check("rd_oe_n", sram_oe_n, 1'b0);
    check("rd_data", codec_rdata, 16'h1234);
    cycle();
    check("rd_keep", o_state, Play);
    codec_read = 1'b1; codec_raddr = 18'h00104; cycle();
    check("rd_end", o_state, Idle);

    // Stop beats record in the same cycle; recording length survives.
    key_play = 1'b1; cycle(); idle_cycles(2);
    key_stop = 1'b1; key_record = 1'b1; cycle();
    check("stop_prio", o_state, Idle);
    key_play = 1'b1; cycle(); idle_cycles(2);
    codec_read = 1'b1; codec_raddr = 18'h000FF; cycle();
    check("len_keep", o_state, Play);
    codec_read = 1'b1; codec_raddr = 18'h00100; cycle();
    check("len_end", o_state, Idle);
    sw_fast = 1'b0; sw_rate = 3'd0;

    // Seconds count and saturation.
    key_record = 1'b1; cycle(); idle_cycles(2);
    for (int i = 0; i < 9; i++) lrck_edge();
    check("secs_9", o_seconds, 8'd2);
    for (int i = 0; i < 1030; i++) lrck_edge();
    check("secs_sat", o_seconds, 8'd255);
    key_stop = 1'b1; cycle();

    // Random phase.
    wptr = '0; rptr = '0;
    for (int i = 0; i < 5000; i++) begin
      if (m_state == Rewind) begin wptr = '0; rptr = '0; end
      if ($urandom_range(0, 299) == 0) wptr = 18'h3FFF8;
      key_stop   = ($urandom_range(0, 79) == 0);
      key_record = ($urandom_range(0, 99) == 0);
      key_play   = ($urandom_range(0, 29) == 0);
      codec_write = $urandom_range(0, 1);
      codec_waddr = wptr;
      codec_wdata = DW'($urandom);
      if (codec_write) wptr = wptr + AW'($urandom_range(1, 2));
      codec_read  = $urandom_range(0, 1);
      codec_raddr = rptr;
      if (codec_read) rptr = rptr + AW'($urandom_range(1, 4));
      tb_rdata = DW'($urandom);
      if ($urandom_range(0, 2) == 0) adclrck = ~adclrck;
      if ($urandom_range(0, 2) == 0) daclrck = ~daclrck;
      if ($urandom_range(0, 15) == 0) begin
        sw_fast = $urandom_range(0, 1);
        sw_rate = 3'($urandom_range(0, 7));
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
